// File: rtl/dll_fc_init_gen_pkg.sv
// Shared DLL definitions: DLCMSM state encodings, DLLP type codes,
// flow-control DLLP field packing and the FC_INIT transmit FSM states.
package dll_fc_init_gen_pkg;

    localparam logic [1:0] DLCM_INACTIVE = 2'd0;
    localparam logic [1:0] DLCM_INIT1    = 2'd1;
    localparam logic [1:0] DLCM_INIT2    = 2'd2;
    localparam logic [1:0] DLCM_ACTIVE   = 2'd3;

    localparam logic [7:0] DLLP_INITFC1_P   = 8'h40;
    localparam logic [7:0] DLLP_INITFC1_NP  = 8'h50;
    localparam logic [7:0] DLLP_INITFC1_CPL = 8'h60;
    localparam logic [7:0] DLLP_INITFC2_P   = 8'hC0;
    localparam logic [7:0] DLLP_INITFC2_NP  = 8'hD0;
    localparam logic [7:0] DLLP_INITFC2_CPL = 8'hE0;
    localparam logic [7:0] DLLP_UPDFC_P     = 8'h80;
    localparam logic [7:0] DLLP_UPDFC_NP    = 8'h90;
    localparam logic [7:0] DLLP_UPDFC_CPL   = 8'hA0;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SEND_P,
        TX_SEND_NP,
        TX_SEND_CPL,
        TX_WAIT
    } tx_state_t;

    typedef struct packed {
        logic p;
        logic np;
        logic cpl;
    } fc_flags_t;

    // Byte0 = type, then HdrFC split across bytes 1/2, DataFC in the low 12 bits.
    function automatic logic [31:0] pack_fc_dllp(input logic [7:0]  dllp_type,
                                                 input logic [7:0]  hdr,
                                                 input logic [11:0] data);
        return {dllp_type, 2'b00, hdr[7:2], hdr[1:0], 2'b00, data[11:8], data[7:0]};
    endfunction

endpackage

// File: rtl/dll_resend_timer.sv
// Resend-interval timer: after a start pulse, expire is high on the
// CYCLES-th following cycle, then the timer goes idle.
module dll_resend_timer #(
    parameter logic [15:0] CYCLES = 16'd8500
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic expire
);

    logic [15:0] cnt;
    logic        running;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= (CYCLES == 16'd0) ? 16'd0 : CYCLES - 16'd1;
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0)
                running <= 1'b0;
            else
                cnt <= cnt - 16'd1;
        end
    end

    assign expire = running && (cnt == '0);

endmodule

// File: rtl/dll_fc_init_gen.sv
// Flow-control initialisation: transmits InitFC1/InitFC2 sets while the link
// is initialising, tracks the partner's InitFC/UpdateFC DLLPs and latches its credits.
module dll_fc_init_gen
    import dll_fc_init_gen_pkg::*;
#(
    parameter logic [7:0]  ADV_PH        = 8'd32,
    parameter logic [11:0] ADV_PD        = 12'd256,
    parameter logic [7:0]  ADV_NPH       = 8'd32,
    parameter logic [11:0] ADV_NPD       = 12'd32,
    parameter logic [7:0]  ADV_CPLH      = 8'd0,
    parameter logic [11:0] ADV_CPLD      = 12'd0,
    parameter logic [15:0] RESEND_CYCLES = 16'd8500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  dlcm_state_i,
    input  logic        rx_dllp_valid_i,
    input  logic [31:0] rx_dllp_i,
    output logic        tx_dllp_valid_o,
    output logic [31:0] tx_dllp_o,
    input  logic        tx_dllp_ready_i,
    output logic        init1_end_o,
    output logic        init2_end_o,
    output logic [7:0]  rmt_ph_o,
    output logic [7:0]  rmt_nph_o,
    output logic [7:0]  rmt_cplh_o,
    output logic [11:0] rmt_pd_o,
    output logic [11:0] rmt_npd_o,
    output logic [11:0] rmt_cpld_o
);

    tx_state_t state, state_nxt;
    logic      set_init2, send_valid, tx_hs, cpl_hs, set_start, in_init;
    logic      timer_expire;

    assign in_init   = (dlcm_state_i == DLCM_INIT1) || (dlcm_state_i == DLCM_INIT2);
    assign tx_hs     = tx_dllp_valid_o && tx_dllp_ready_i;
    assign cpl_hs    = (state == TX_SEND_CPL) && tx_hs;
    assign set_start = (state_nxt == TX_SEND_P) && (state != TX_SEND_P);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TX_IDLE;
            set_init2 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (set_start)
                set_init2 <= (dlcm_state_i == DLCM_INIT2);
        end
    end

    // A DLLP on offer is always finished before honouring a leave-init request.
    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:     if (in_init) state_nxt = TX_SEND_P;
            TX_SEND_P:   if (tx_hs) state_nxt = in_init ? TX_SEND_NP : TX_IDLE;
            TX_SEND_NP:  if (tx_hs) state_nxt = in_init ? TX_SEND_CPL : TX_IDLE;
            TX_SEND_CPL: if (tx_hs) state_nxt = in_init ? TX_WAIT : TX_IDLE;
            TX_WAIT: begin
                if (!in_init)         state_nxt = TX_IDLE;
                else if (timer_expire) state_nxt = TX_SEND_P;
            end
            default:     state_nxt = TX_IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        send_valid = 1'b0;
        tx_dllp_o  = '0;
        case (state)
            TX_SEND_P: begin
                send_valid = 1'b1;
                tx_dllp_o  = pack_fc_dllp(set_init2 ? DLLP_INITFC2_P : DLLP_INITFC1_P, ADV_PH, ADV_PD);
            end
            TX_SEND_NP: begin
                send_valid = 1'b1;
                tx_dllp_o  = pack_fc_dllp(set_init2 ? DLLP_INITFC2_NP : DLLP_INITFC1_NP, ADV_NPH, ADV_NPD);
            end
            TX_SEND_CPL: begin
                send_valid = 1'b1;
                tx_dllp_o  = pack_fc_dllp(set_init2 ? DLLP_INITFC2_CPL : DLLP_INITFC1_CPL, ADV_CPLH, ADV_CPLD);
            end
            default: ;
        endcase
    end

    // Gating with rst keeps a reset mid-set from completing the handshake.
    assign tx_dllp_valid_o = send_valid && !rst;

    dll_resend_timer #(
        .CYCLES (RESEND_CYCLES)
    ) u_resend_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (cpl_hs),
        .expire (timer_expire)
    );

    logic [7:0]  rx_type, rx_hdr;
    logic [11:0] rx_data;
    fc_flags_t   rx_init, fl, fl_nxt;
    logic        rx_fi2_evt, fi2, fi2_nxt, sent, sent_nxt, done1, done2;
    logic        init1_fire, init2_fire, inactive;
    logic [1:0]  dlcm_q;
    logic        unused_rsvd;

    assign rx_type     = rx_dllp_i[31:24];
    assign rx_hdr      = {rx_dllp_i[21:16], rx_dllp_i[15:14]};
    assign rx_data     = rx_dllp_i[11:0];
    assign unused_rsvd = ^{rx_dllp_i[23:22], rx_dllp_i[13:12]};
    assign inactive    = (dlcm_state_i == DLCM_INACTIVE);

    assign rx_init.p   = rx_dllp_valid_i && (rx_type == DLLP_INITFC1_P   || rx_type == DLLP_INITFC2_P);
    assign rx_init.np  = rx_dllp_valid_i && (rx_type == DLLP_INITFC1_NP  || rx_type == DLLP_INITFC2_NP);
    assign rx_init.cpl = rx_dllp_valid_i && (rx_type == DLLP_INITFC1_CPL || rx_type == DLLP_INITFC2_CPL);
    assign rx_fi2_evt  = rx_dllp_valid_i && (dlcm_state_i == DLCM_INIT2) &&
                         (rx_type inside {DLLP_INITFC2_P, DLLP_INITFC2_NP, DLLP_INITFC2_CPL,
                                          DLLP_UPDFC_P, DLLP_UPDFC_NP, DLLP_UPDFC_CPL});

    // Next-state flags so an rx DLLP coinciding with the Cpl handshake still counts.
    always_comb begin
        fl_nxt   = fl | rx_init;
        fi2_nxt  = fi2 | rx_fi2_evt;
        sent_nxt = (dlcm_state_i != dlcm_q) ? 1'b0 : (sent | cpl_hs);
        if (inactive) begin
            fl_nxt  = '0;
            fi2_nxt = 1'b0;
        end
    end

    assign init1_fire = (dlcm_state_i == DLCM_INIT1) && (&fl_nxt) && sent_nxt && !done1;
    assign init2_fire = (dlcm_state_i == DLCM_INIT2) && fi2_nxt && sent_nxt && !done2;

    always_ff @(posedge clk) begin
        if (rst) begin
            fl          <= '0;
            fi2         <= 1'b0;
            sent        <= 1'b0;
            done1       <= 1'b0;
            done2       <= 1'b0;
            dlcm_q      <= DLCM_INACTIVE;
            init1_end_o <= 1'b0;
            init2_end_o <= 1'b0;
            rmt_ph_o    <= '0;
            rmt_pd_o    <= '0;
            rmt_nph_o   <= '0;
            rmt_npd_o   <= '0;
            rmt_cplh_o  <= '0;
            rmt_cpld_o  <= '0;
        end else begin
            fl          <= fl_nxt;
            fi2         <= fi2_nxt;
            sent        <= sent_nxt;
            dlcm_q      <= dlcm_state_i;
            init1_end_o <= init1_fire;
            init2_end_o <= init2_fire;
            done1       <= !inactive && (done1 || init1_fire);
            done2       <= !inactive && (done2 || init2_fire);
            if (inactive) begin
                rmt_ph_o   <= '0;
                rmt_pd_o   <= '0;
                rmt_nph_o  <= '0;
                rmt_npd_o  <= '0;
                rmt_cplh_o <= '0;
                rmt_cpld_o <= '0;
            end else begin
                if (rx_init.p && !fl.p) begin
                    rmt_ph_o <= rx_hdr;
                    rmt_pd_o <= rx_data;
                end
                if (rx_init.np && !fl.np) begin
                    rmt_nph_o <= rx_hdr;
                    rmt_npd_o <= rx_data;
                end
                if (rx_init.cpl && !fl.cpl) begin
                    rmt_cplh_o <= rx_hdr;
                    rmt_cpld_o <= rx_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dll_fc_init_gen.sv
// Self-checking bench for dll_fc_init_gen: scoreboard of transmitted DLLPs,
// table of received DLLPs with expected partner credits, and reset/stall sequences.
module tb_dll_fc_init_gen;

    localparam int RESEND = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dlcm;
    logic        rx_valid;
    logic [31:0] rx_dllp;
    logic        tx_valid;
    logic [31:0] tx_dllp;
    logic        tx_ready;
    logic        init1_end, init2_end;
    logic [7:0]  rmt_ph, rmt_nph, rmt_cplh;
    logic [11:0] rmt_pd, rmt_npd, rmt_cpld;

    dll_fc_init_gen #(
        .RESEND_CYCLES (16'(RESEND))
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dlcm_state_i    (dlcm),
        .rx_dllp_valid_i (rx_valid),
        .rx_dllp_i       (rx_dllp),
        .tx_dllp_valid_o (tx_valid),
        .tx_dllp_o       (tx_dllp),
        .tx_dllp_ready_i (tx_ready),
        .init1_end_o     (init1_end),
        .init2_end_o     (init2_end),
        .rmt_ph_o        (rmt_ph),
        .rmt_nph_o       (rmt_nph),
        .rmt_cplh_o      (rmt_cplh),
        .rmt_pd_o        (rmt_pd),
        .rmt_npd_o       (rmt_npd),
        .rmt_cpld_o      (rmt_cpld)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          init1_cnt, init2_cnt, init1_cyc, init2_cyc;
    logic [31:0] exp_q[$];
    int          hs_cyc_q[$];

    typedef struct {
        logic [31:0] dllp;
        logic [7:0]  ph, nph, cplh;
        logic [11:0] pd, npd, cpld;
    } rx_vec_t;

    function automatic logic [31:0] fc_dllp(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
        logic [31:0] w;
        w = 32'(t) << 24;
        w = w | (32'(h >> 2) << 16);
        w = w | (32'(h & 8'h03) << 14);
        w = w | 32'(d);
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_set(input bit init2);
        logic [7:0] base;
        base = init2 ? 8'hC0 : 8'h40;
        exp_q.push_back(fc_dllp(base,         8'd32, 12'd256));
        exp_q.push_back(fc_dllp(base + 8'h10, 8'd32, 12'd32));
        exp_q.push_back(fc_dllp(base + 8'h20, 8'd0,  12'd0));
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        check({"drain_", name}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Output monitor: pulse bookkeeping and scoreboard pops on each handshake.
    always @(negedge clk) begin
        if (init1_end) begin
            init1_cnt++;
            init1_cyc = cyc;
        end
        if (init2_end) begin
            init2_cnt++;
            init2_cyc = cyc;
        end
        if (tx_valid && tx_ready) begin
            hs_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tx: got 0x%0h, expected no DLLP", tx_dllp);
            end else begin
                check("tx_dllp", tx_dllp, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_vec_t vecs[7];
        int      cpl_cyc;

        vecs[0] = '{fc_dllp(8'h40, 8'h10, 12'h080), 8'h10, 8'h00, 8'h00, 12'h080, 12'h000, 12'h000};
        vecs[1] = '{fc_dllp(8'h50, 8'h05, 12'h0AB), 8'h10, 8'h05, 8'h00, 12'h080, 12'h0AB, 12'h000};
        vecs[2] = '{fc_dllp(8'h60, 8'h03, 12'h004), 8'h10, 8'h05, 8'h03, 12'h080, 12'h0AB, 12'h004};
        vecs[3] = '{fc_dllp(8'h40, 8'h20, 12'h111), 8'h10, 8'h05, 8'h03, 12'h080, 12'h0AB, 12'h004};
        vecs[4] = '{fc_dllp(8'hD0, 8'h7F, 12'hFFF), 8'h10, 8'h05, 8'h03, 12'h080, 12'h0AB, 12'h004};
        vecs[5] = '{fc_dllp(8'h80, 8'hAA, 12'h555), 8'h10, 8'h05, 8'h03, 12'h080, 12'h0AB, 12'h004};
        vecs[6] = '{fc_dllp(8'h00, 8'hFF, 12'hFFF), 8'h10, 8'h05, 8'h03, 12'h080, 12'h0AB, 12'h004};

        rst = 1'b1; dlcm = 2'd0; rx_valid = 1'b0; rx_dllp = '0; tx_ready = 1'b1;
        init1_cnt = 0; init2_cnt = 0; init1_cyc = 0; init2_cyc = 0; cpl_cyc = 0;
        tick(3);
        check("reset_valid", 32'(tx_valid), 0);
        check("reset_init1_end", 32'(init1_end), 0);
        check("reset_init2_end", 32'(init2_end), 0);
        check("reset_rmt_ph", 32'(rmt_ph), 0);
        check("reset_rmt_pd", 32'(rmt_pd), 0);
        check("reset_rmt_cpld", 32'(rmt_cpld), 0);

        // INIT1, no rx: two sets separated by the resend gap, no init1_end.
        rst = 1'b0; dlcm = 2'd1; hs_cyc_q.delete();
        push_set(0);
        drain("s1_first", 20);
        push_set(0);
        drain("s1_second", RESEND + 20);
        check("s1_hs_count", 32'(hs_cyc_q.size()), 6);
        if (hs_cyc_q.size() == 6) begin
            check("s1_np_after_p", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 1);
            check("s1_cpl_after_np", 32'(hs_cyc_q[2] - hs_cyc_q[1]), 1);
            check("s1_resend_gap", 32'(hs_cyc_q[3] - hs_cyc_q[2]), 32'(RESEND + 1));
            check("s1_np_after_p_2", 32'(hs_cyc_q[4] - hs_cyc_q[3]), 1);
        end
        check("s1_no_init1_end", 32'(init1_cnt), 0);
        dlcm = 2'd0;
        tick(3);

        // INIT1: first set, then partner InitFC DLLPs from the table.
        init1_cnt = 0; init2_cnt = 0;
        dlcm = 2'd1;
        push_set(0);
        drain("s2", 20);
        for (int i = 0; i < 7; i++) begin
            rx_valid = 1'b1;
            rx_dllp  = vecs[i].dllp;
            if (i == 2) cpl_cyc = cyc;
            tick(1);
            rx_valid = 1'b0;
            check($sformatf("rmt_ph[%0d]", i),   32'(rmt_ph),   32'(vecs[i].ph));
            check($sformatf("rmt_pd[%0d]", i),   32'(rmt_pd),   32'(vecs[i].pd));
            check($sformatf("rmt_nph[%0d]", i),  32'(rmt_nph),  32'(vecs[i].nph));
            check($sformatf("rmt_npd[%0d]", i),  32'(rmt_npd),  32'(vecs[i].npd));
            check($sformatf("rmt_cplh[%0d]", i), 32'(rmt_cplh), 32'(vecs[i].cplh));
            check($sformatf("rmt_cpld[%0d]", i), 32'(rmt_cpld), 32'(vecs[i].cpld));
        end
        tick(1);
        check("s2_init1_end_count", 32'(init1_cnt), 1);
        check("s2_init1_end_cycle", 32'(init1_cyc), 32'(cpl_cyc + 1));
        check("s2_no_init2_end", 32'(init2_cnt), 0);
        dlcm = 2'd0;
        tick(3);

        // INACTIVE clears partner credits; then a 5-cycle ready stall on P.
        check("inactive_rmt_ph", 32'(rmt_ph), 0);
        check("inactive_rmt_npd", 32'(rmt_npd), 0);
        check("inactive_rmt_cplh", 32'(rmt_cplh), 0);
        tx_ready = 1'b0; dlcm = 2'd1;
        push_set(0);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_valid[%0d]", i), 32'(tx_valid), 1);
            check($sformatf("stall_dllp[%0d]", i), tx_dllp, exp_q[0]);
            tick(1);
        end
        tx_ready = 1'b1;
        drain("s3", 20);
        dlcm = 2'd0;
        tick(3);

        // INIT2 with an early UpdateFC-P: init2_end right after the Cpl handshake.
        init1_cnt = 0; init2_cnt = 0; hs_cyc_q.delete();
        dlcm = 2'd2;
        rx_valid = 1'b1;
        rx_dllp  = fc_dllp(8'h80, 8'h01, 12'h001);
        push_set(1);
        tick(1);
        rx_valid = 1'b0;
        drain("s4", 20);
        tick(2);
        check("s4_init2_end_count", 32'(init2_cnt), 1);
        check("s4_hs_count", 32'(hs_cyc_q.size()), 3);
        if (hs_cyc_q.size() == 3)
            check("s4_init2_end_cycle", 32'(init2_cyc), 32'(hs_cyc_q[2] + 1));
        check("s4_no_init1_end", 32'(init1_cnt), 0);
        dlcm = 2'd0;
        tick(3);

        // Reset in SEND_NP: valid drops at once, credits clear, resend starts at P.
        init1_cnt = 0; init2_cnt = 0;
        dlcm = 2'd1;
        rx_valid = 1'b1;
        rx_dllp  = fc_dllp(8'h40, 8'h44, 12'h123);
        exp_q.push_back(fc_dllp(8'h40, 8'd32, 12'd256));
        tick(1);
        rx_valid = 1'b0;
        drain("s5_p", 10);
        check("s5_rmt_ph_before_rst", 32'(rmt_ph), 32'h44);
        rst = 1'b1;
        #1;
        check("s5_valid_during_rst", 32'(tx_valid), 0);
        tick(1);
        check("s5_valid_after_rst", 32'(tx_valid), 0);
        check("s5_rmt_ph_after_rst", 32'(rmt_ph), 0);
        check("s5_rmt_pd_after_rst", 32'(rmt_pd), 0);
        rst = 1'b0;
        push_set(0);
        drain("s5_restart", 20);
        check("s5_no_init1_end", 32'(init1_cnt), 0);
        dlcm = 2'd0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dll_fc_init_gen.md
DLL_FC_INIT_GEN -- requirements
Module: dll_fc_init_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  ADV_PH, 8'd32, advertised Posted header credits
  ADV_PD, 12'd256, advertised Posted data credits
  ADV_NPH, 8'd32, advertised Non-Posted header credits
  ADV_NPD, 12'd32, advertised Non-Posted data credits
  ADV_CPLH, 8'd0, advertised Completion header credits (0 = infinite)
  ADV_CPLD, 12'd0, advertised Completion data credits (0 = infinite)
  RESEND_CYCLES, 16'd8500, idle gap between repeated FC sets
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk, in, 1, sole clock
  rst, in, 1, synchronous active-high reset
  dlcm_state_i, in, 2, DLCMSM state: 0 INACTIVE, 1 INIT1, 2 INIT2, 3 ACTIVE
  rx_dllp_valid_i, in, 1, received DLLP strobe, one DLLP per cycle, CRC already checked
  rx_dllp_i, in, 32, received DLLP; [31:24] byte0 ... [7:0] byte3
  tx_dllp_valid_o, out, 1, DLLP offered to the DLLP mux
  tx_dllp_o, out, 32, DLLP to transmit, same byte order
  tx_dllp_ready_i, in, 1, mux accepts when valid and ready are both high
  init1_end_o, out, 1, one-cycle pulse: FC_INIT1 complete
  init2_end_o, out, 1, one-cycle pulse: FC_INIT2 complete
  rmt_ph_o/rmt_nph_o/rmt_cplh_o, out, 8 each, link-partner header credits
  rmt_pd_o/rmt_npd_o/rmt_cpld_o, out, 12 each, link-partner data credits

Function
REQ-003 DLLP encoding SHALL be: byte0 = type; byte1 = {2'b00, Hdr[7:2]}; byte2 = {Hdr[1:0], 2'b00, Data[11:8]}; byte3 = Data[7:0]. VC0 only.
REQ-004 Type codes SHALL be: InitFC1 P/NP/Cpl 0x40/0x50/0x60; InitFC2 0xC0/0xD0/0xE0; UpdateFC 0x80/0x90/0xA0.
REQ-005 The TX FSM states SHALL be IDLE, SEND_P, SEND_NP, SEND_CPL, WAIT.
REQ-006 IDLE->SEND_P SHALL occur when dlcm_state_i is INIT1 or INIT2. Each SEND_x holds tx_dllp_valid_o high with a stable DLLP until the handshake, then advances P->NP->Cpl->WAIT.
REQ-007 The DLLP type SHALL be selected per item from the dlcm_state_i sampled on entry to SEND_P: INIT1 selects InitFC1, INIT2 selects InitFC2. The whole set uses that type.
REQ-008 WAIT SHALL count RESEND_CYCLES cycles, then return to SEND_P while dlcm_state_i is INIT1 or INIT2, else go to IDLE.
REQ-009 If dlcm_state_i is ACTIVE or INACTIVE, the FSM SHALL go to IDLE. A DLLP already being offered is completed first.
REQ-010 Flags fl1_p, fl1_np and fl1_cpl SHALL each be set by receipt of an InitFC1 or InitFC2 of that type. FI1 = AND of the three.
REQ-011 FI2 SHALL be set by receipt of any InitFC2 or UpdateFC DLLP while in INIT2.
REQ-012 A sent-set flag SHALL set on the SEND_CPL handshake and clear whenever dlcm_state_i changes value.
REQ-013 init1_end_o SHALL pulse exactly once, one cycle after FI1 and sent-set are both first true in INIT1.
REQ-014 init2_end_o SHALL pulse exactly once, one cycle after FI2 and sent-set are both first true in INIT2.
REQ-015 An rx DLLP in the same cycle as the Cpl handshake SHALL count toward REQ-013 and REQ-014.
REQ-016 On the first InitFC1 or InitFC2 of each type, the corresponding rmt_* outputs SHALL latch Hdr and Data. Later InitFC DLLPs and all other types SHALL NOT modify them.
REQ-017 Unknown DLLP types (Ack, Nak, PM, vendor) SHALL be ignored with no state change.
REQ-018 When dlcm_state_i is INACTIVE, all flags and rmt_* SHALL clear.

Reset
REQ-019 rst SHALL put the FSM in IDLE, clear all flags, counters and rmt_*, and drive tx_dllp_valid_o, init1_end_o and init2_end_o to 0 in the following cycle.
REQ-020 rst asserted mid-set SHALL drop tx_dllp_valid_o without completing the handshake.

Structure
REQ-021 A shared DLL package SHALL hold the DLCMSM state encodings, the DLLP type codes, and a DLLP field-pack function.
REQ-022 The resend interval counter SHALL be one sub-module, dll_resend_timer (start, expire).

Verification
REQ-023 INIT1 with ready=1 and no rx -> P, NP, Cpl sent on 3 consecutive cycles (0x40/0x50/0x60 bytes0), a RESEND_CYCLES gap, then the set repeats, and init1_end_o never pulses.
REQ-024 INIT1 with rx InitFC1 P (Hdr 0x10, Data 0x080), NP and Cpl after the first set completes -> init1_end_o pulses once, rmt_ph_o=0x10 and rmt_pd_o=0x080.
REQ-025 INIT1 with ready held low for 5 cycles -> tx_dllp_o is stable, valid stays high, and there is no skip.
REQ-026 INIT2, then rx UpdateFC-P before any set is sent -> init2_end_o pulses the cycle after the first Cpl handshake, and the sent DLLPs use 0xC0/0xD0/0xE0.
REQ-027 rst pulsed during SEND_NP -> the next cycle has valid=0 and flags cleared; on release in INIT1, sending restarts at P.
REQ-028 Second InitFC1-P with Hdr 0x20 after a first with 0x10 -> rmt_ph_o stays 0x10.
